sm83_irq_ctrl: RTL and testbench

SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

---
 rtl/sm83_irq_ctrl_if.sv | 30 +++
 rtl/sm83_irq_ctrl.sv | 111 +++++++++++
 tb/tb_sm83_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm83_irq_ctrl_if.sv
// CPU-side register bus of the SM83 interrupt controller.
// Handshake: p_rd/p_wr are level strobes qualified by adr, with no ready/wait.
// The slave always accepts a strobe in the cycle it is presented. oe marks
// dout valid in the same cycle as p_rd.
interface sm83_irq_ctrl_if;
  logic [15:0] adr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        oe;
  logic        p_rd;
  logic        p_wr;

  modport master (
    output adr,
    output din,
    output p_rd,
    output p_wr,
    input  dout,
    input  oe
  );

  modport slave (
    input  adr,
    input  din,
    input  p_rd,
    input  p_wr,
    output dout,
    output oe
  );
endinterface

// File: rtl/sm83_irq_ctrl.sv
// SM83-style interrupt controller: edge-detected IF flags, 8-bit IE mask,
// registered irq outputs, and acks taken on iack rising edges.
module sm83_irq_ctrl #(
  parameter int          NUM_SRC = 5,
  parameter logic [15:0] IF_ADR  = 16'hFF0F,
  parameter logic [15:0] IE_ADR  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               n_reset,
  sm83_irq_ctrl_if.slave     bus,
  input  logic [NUM_SRC-1:0] src,
  output logic [7:0]         irq,
  input  logic [7:0]         iack
);

  logic [NUM_SRC-1:0] if_q;
  logic [NUM_SRC-1:0] if_base;
  logic [NUM_SRC-1:0] if_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_edge;
  logic [7:0]         ie_q;
  logic [7:0]         ie_d;
  logic [7:0]         iack_q;
  logic [7:0]         ack8;
  logic [7:0]         irq_d;
  logic [7:0]         if_word;
  logic               wr_q;
  logic               wr_stb;
  logic               sel_if;
  logic               sel_ie;
  logic               unused_ack;

  // Address decode and write strobe. A simultaneous read suppresses the write.
  always_comb begin
    sel_if = (bus.adr == IF_ADR);
    sel_ie = (bus.adr == IE_ADR);
    wr_stb = bus.p_wr & ~wr_q & ~bus.p_rd;
  end

  // Rising-edge detectors for requests and acknowledges.
  always_comb begin
    src_edge   = src & ~src_q;
    ack8       = iack & ~iack_q;
    unused_ack = ^ack8;
  end

  // Next flag value. The new edge is ORed in last, so it wins over a clear
  // from an ack or a CPU write in the same cycle.
  always_comb begin
    if_base = if_q;
    if (wr_stb && sel_if) begin
      if_base = bus.din[NUM_SRC-1:0];
    end
    if_d = (if_base & ~ack8[NUM_SRC-1:0]) | src_edge;
  end

  always_comb begin
    ie_d = ie_q;
    if (wr_stb && sel_ie) begin
      ie_d = bus.din;
    end
  end

  // irq is taken from the registered flags, one cycle behind IF/IE.
  always_comb begin
    irq_d                = 8'h00;
    irq_d[NUM_SRC-1:0]   = if_q & ie_q[NUM_SRC-1:0];
  end

  // Edge-detect history. Reset values block spurious events at reset release.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      src_q  <= '1;
      iack_q <= 8'h00;
      wr_q   <= 1'b1;
    end else begin
      src_q  <= src;
      iack_q <= iack;
      wr_q   <= bus.p_wr;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      if_q <= '0;
      ie_q <= 8'h00;
      irq  <= 8'h00;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
      irq  <= irq_d;
    end
  end

  // Read path. Unimplemented IF bits read as 1. No write bypass.
  always_comb begin
    if_word              = 8'hFF;
    if_word[NUM_SRC-1:0] = if_q;
  end

  always_comb begin
    bus.oe   = bus.p_rd & (sel_if | sel_ie);
    bus.dout = 8'h00;
    if (sel_if) begin
      bus.dout = if_word;
    end else if (sel_ie) begin
      bus.dout = ie_q;
    end
  end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl: directed scenarios, then randomized traffic,
// all checked against a flag/mask reference model held in the bench.
module tb_sm83_irq_ctrl;
  localparam int          NUM_SRC  = 5;
  localparam logic [15:0] IF_A     = 16'hFF0F;
  localparam logic [15:0] IE_A     = 16'hFFFF;
  localparam logic [7:0]  SRC_MASK = 8'h1F;

  // clock / reset
  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic [NUM_SRC-1:0] src;
  logic [7:0]         irq;
  logic [7:0]         iack;

  sm83_irq_ctrl_if bus ();

  sm83_irq_ctrl #(
    .NUM_SRC (NUM_SRC),
    .IF_ADR  (IF_A),
    .IE_ADR  (IE_A)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus),
    .src     (src),
    .irq     (irq),
    .iack    (iack)
  );

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q[$];

  // reference model: flag byte, mask byte, irq byte, previous input levels
  logic [7:0] m_if, m_ie, m_irq, m_src_prev, m_iack_prev;
  logic       m_wr_prev;

  function automatic void model_reset();
    m_if        = 8'h00;
    m_ie        = 8'h00;
    m_irq       = 8'h00;
    m_src_prev  = 8'hFF;
    m_iack_prev = 8'h00;
    m_wr_prev   = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic       exp_oe;
    logic [7:0] exp_dout;
    exp_oe   = bus.p_rd && (bus.adr == IF_A || bus.adr == IE_A);
    exp_dout = (bus.adr == IF_A) ? (8'hE0 | m_if) :
               (bus.adr == IE_A) ? m_ie : 8'h00;
    exp_q.push_back(exp_dout);
    chk("irq", irq, m_irq);
    chk("oe", {7'b0, bus.oe}, {7'b0, exp_oe});
    chk("dout", bus.dout, exp_q.pop_front());
  endtask

  // One clock: evaluate the rules on the pre-edge inputs, then compare.
  task automatic cycle();
    logic [7:0] rises, acks, n_if, n_ie, n_irq;
    bit         wrote;
    rises = {3'b000, src} & ~m_src_prev;
    acks  = iack & ~m_iack_prev;
    wrote = bus.p_wr && !m_wr_prev && !bus.p_rd;
    n_if  = m_if;
    if (wrote && bus.adr == IF_A) n_if = bus.din;
    n_if  = ((n_if & ~acks) | rises) & SRC_MASK;
    n_ie  = (wrote && bus.adr == IE_A) ? bus.din : m_ie;
    n_irq = m_if & m_ie & SRC_MASK;
    @(posedge clk);
    if (n_reset) begin
      m_if        = n_if;
      m_ie        = n_ie;
      m_irq       = n_irq;
      m_src_prev  = {3'b111, src};
      m_iack_prev = iack;
      m_wr_prev   = bus.p_wr;
    end else begin
      model_reset();
    end
    #1;
    check_all();
  endtask

  // driver tasks
  task automatic do_reset();
    n_reset = 1'b0;
    model_reset();
    cycle();
    cycle();
    n_reset = 1'b1;
    cycle();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus.adr  = a;
    bus.din  = d;
    bus.p_wr = 1'b1;
    cycle();
    bus.p_wr = 1'b0;
    cycle();
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.adr  = a;
    bus.p_rd = 1'b1;
    #1;
    chk(tag, bus.dout, exp);
    chk({tag, "_oe"}, {7'b0, bus.oe}, 8'h01);
    bus.p_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset  = 1'b0;
    src      = '0;
    iack     = 8'h00;
    bus.adr  = 16'h0000;
    bus.din  = 8'h00;
    bus.p_rd = 1'b0;
    bus.p_wr = 1'b0;
    model_reset();

    // reset state
    do_reset();
    chk("rst_irq", irq, 8'h00);
    read_chk("rst_if", IF_A, 8'hE0);
    read_chk("rst_ie", IE_A, 8'h00);

    // src edge sets IF, irq follows one cycle later
    bus_write(IE_A, 8'h04);
    src[2] = 1'b1;
    cycle();
    read_chk("edge_if", IF_A, 8'hE4);
    chk("edge_irq_early", irq, 8'h00);
    cycle();
    chk("edge_irq", irq, 8'h04);

    // held iack clears once
    iack = 8'h04;
    cycle();
    read_chk("ack_if", IF_A, 8'hE0);
    chk("ack_irq_lag", irq, 8'h04);
    cycle();
    chk("ack_irq", irq, 8'h00);
    cycle();
    read_chk("ack_if_held", IF_A, 8'hE0);
    iack = 8'h00;
    cycle();

    // edge beats simultaneous ack
    src = '0;
    cycle();
    src[0] = 1'b1;
    cycle();
    src[0] = 1'b0;
    cycle();
    read_chk("pre_race_if", IF_A, 8'hE1);
    src[0]  = 1'b1;
    iack[0] = 1'b1;
    cycle();
    read_chk("race_if", IF_A, 8'hE1);
    iack = 8'h00;
    src  = '0;
    cycle();

    // held p_wr writes once; data change while held must not land
    bus.adr  = IF_A;
    bus.din  = 8'hFF;
    bus.p_wr = 1'b1;
    cycle();
    bus.din = 8'h00;
    cycle();
    cycle();
    cycle();
    read_chk("held_wr_if", IF_A, 8'hFF);
    bus.p_wr = 1'b0;
    cycle();
    bus_write(IF_A, 8'h00);
    read_chk("second_wr_if", IF_A, 8'hE0);

    // write during read is ignored; foreign address is ignored
    bus.adr  = IE_A;
    bus.din  = 8'hAA;
    bus.p_wr = 1'b1;
    bus.p_rd = 1'b1;
    cycle();
    bus.p_wr = 1'b0;
    bus.p_rd = 1'b0;
    cycle();
    read_chk("rd_wr_ie", IE_A, 8'h04);
    bus_write(16'hFF10, 8'hFF);
    bus.adr  = 16'hFF10;
    bus.p_rd = 1'b1;
    #1;
    chk("other_dout", bus.dout, 8'h00);
    chk("other_oe", {7'b0, bus.oe}, 8'h00);
    bus.p_rd = 1'b0;
    read_chk("other_if", IF_A, 8'hE0);

    // src high through reset release sets nothing
    src = 5'h1F;
    do_reset();
    cycle();
    chk("rel_irq", irq, 8'h00);
    read_chk("rel_if", IF_A, 8'hE0);
    src[4] = 1'b0;
    cycle();
    src[4] = 1'b1;
    cycle();
    read_chk("rel_edge_if", IF_A, 8'hF0);
    src = '0;

    // async reset between edges
    bus_write(IE_A, 8'hFF);
    bus_write(IF_A, 8'hFF);
    cycle();
    chk("pre_async_irq", irq, 8'h1F);
    #1;
    n_reset = 1'b0;
    model_reset();
    #1;
    chk("async_irq", irq, 8'h00);
    read_chk("async_if", IF_A, 8'hE0);
    cycle();
    read_chk("async_ie", IE_A, 8'h00);
    n_reset = 1'b1;
    cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) src = NUM_SRC'($urandom);
      if ($urandom_range(0, 3) == 0) iack = 8'($urandom);
      case ($urandom_range(0, 3))
        0: bus.adr = IF_A;
        1: bus.adr = IE_A;
        2: bus.adr = 16'($urandom);
        default: bus.adr = IF_A;
      endcase
      bus.din  = 8'($urandom);
      bus.p_rd = ($urandom_range(0, 2) == 0);
      bus.p_wr = ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
